// File: rtl/conv_sequencer.sv
// Address/strobe sequencer for a 3-row convolution pass: one weight fetch, N_ROWS row reads, N_ROWS-2 output writes.
// Optional macro CONV_SEQ_PERF_COUNT_EN builds the busy-cycle counter on cycle_count.
module conv_sequencer #(
   parameter int ADDR_W   = 12,
   parameter int N_ROWS   = 16,
   parameter int IN_BASE  = 0,
   parameter int OUT_BASE = 256,
   parameter int W_ADDR   = 0
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              go,
   output logic              busy,
   output logic [ADDR_W-1:0] dut_wmem_read_address,
   output logic [ADDR_W-1:0] dut_sram_read_address,
   output logic              weight_load,
   output logic              row_load,
   output logic              dut_sram_write_enable,
   output logic [ADDR_W-1:0] dut_sram_write_address,
   output logic              done,
   output logic [15:0]       cycle_count
);

   typedef enum logic [2:0] {IDLE, FETCH_W, STREAM, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_ROWS - 1);
   localparam logic [ADDR_W-1:0] IN_B     = ADDR_W'(IN_BASE);
   localparam logic [ADDR_W-1:0] OUT_B    = ADDR_W'(OUT_BASE);
   localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(W_ADDR);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

   state_t            state;
   logic [ADDR_W-1:0] r;          // row whose address is currently on the read port
   logic [ADDR_W-1:0] load_row;   // row whose data is being shifted in this cycle
   logic              last_write; // the write on the port now is the final one

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state                  <= IDLE;
         r                      <= '0;
         load_row               <= '0;
         last_write             <= 1'b0;
         busy                   <= 1'b0;
         dut_wmem_read_address  <= '0;
         dut_sram_read_address  <= '0;
         weight_load            <= 1'b0;
         row_load               <= 1'b0;
         dut_sram_write_enable  <= 1'b0;
         dut_sram_write_address <= '0;
         done                   <= 1'b0;
      end else begin
         weight_load           <= 1'b0;
         row_load              <= 1'b0;
         dut_sram_write_enable <= 1'b0;
         done                  <= 1'b0;
         last_write            <= row_load && (load_row == LAST_ROW);

         // A write trails its row load by one cycle; the first two rows only prime the window.
         if (row_load && (load_row >= TWO)) begin
            dut_sram_write_enable  <= 1'b1;
            dut_sram_write_address <= OUT_B + load_row - TWO;
         end

         case (state)
            IDLE: begin
               if (go) begin
                  state                 <= FETCH_W;
                  busy                  <= 1'b1;
                  r                     <= '0;
                  dut_wmem_read_address <= W_A;
               end
            end
            FETCH_W: begin
               state                 <= STREAM;
               weight_load           <= 1'b1;
               dut_sram_read_address <= IN_B + r;
            end
            STREAM: begin
               row_load <= 1'b1;
               load_row <= r;
               if (r == LAST_ROW) begin
                  state <= DRAIN;
               end else begin
                  r                     <= r + ONE;
                  dut_sram_read_address <= IN_B + r + ONE;
               end
            end
            DRAIN: begin
               if (last_write) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef CONV_SEQ_PERF_COUNT_EN
   logic [15:0] count;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         count <= '0;
      end else if (state == IDLE && go) begin
         count <= '0;
      end else if (busy && count != 16'hFFFF) begin
         count <= count + 16'd1;
      end
   end

   assign cycle_count = count;
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: per-cycle expected-output tables built from the timing rules,
// plus hand sequences for reset behaviour. Two instances: default (N=16) and N_ROWS=3/OUT_BASE=4095.
module tb_conv_sequencer;

   typedef struct packed {
      logic        busy;
      logic [11:0] wmem;
      logic [11:0] rd;
      logic        wl;
      logic        rl;
      logic        we;
      logic [11:0] wa;
      logic        done;
      logic [15:0] cc;
   } obs_t;

   typedef struct packed {
      logic go;
      obs_t exp;
   } vec_t;

`ifdef CONV_SEQ_PERF_COUNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_b = 1'b0;
   logic go_a = 1'b0;
   logic go_b = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic        busy_a, wl_a, rl_a, we_a, done_a;
   logic [11:0] wmem_a, rd_a, wa_a;
   logic [15:0] cc_a;
   logic        busy_b, wl_b, rl_b, we_b, done_b;
   logic [11:0] wmem_b, rd_b, wa_b;
   logic [15:0] cc_b;
   obs_t        obs_a, obs_b;

   always #5 clk = ~clk;

   conv_sequencer dut_a (
      .clk(clk), .reset_b(reset_b), .go(go_a), .busy(busy_a),
      .dut_wmem_read_address(wmem_a), .dut_sram_read_address(rd_a),
      .weight_load(wl_a), .row_load(rl_a), .dut_sram_write_enable(we_a),
      .dut_sram_write_address(wa_a), .done(done_a), .cycle_count(cc_a)
   );

   conv_sequencer #(.N_ROWS(3), .OUT_BASE(4095)) dut_b (
      .clk(clk), .reset_b(reset_b), .go(go_b), .busy(busy_b),
      .dut_wmem_read_address(wmem_b), .dut_sram_read_address(rd_b),
      .weight_load(wl_b), .row_load(rl_b), .dut_sram_write_enable(we_b),
      .dut_sram_write_address(wa_b), .done(done_b), .cycle_count(cc_b)
   );

   assign obs_a = {busy_a, wmem_a, rd_a, wl_a, rl_a, we_a, wa_a, done_a, cc_a};
   assign obs_b = {busy_b, wmem_b, rd_b, wl_b, rl_b, we_b, wa_b, done_b, cc_b};

   task automatic set_go(input int sel, input logic v);
      if (sel == 0) go_a = v;
      else          go_b = v;
   endtask

   task automatic show_fail(input string name, input int cyc, input obs_t got, input obs_t exp);
      $display("FAIL %s cycle=%0d got busy=%0b wmem=%0d rd=%0d wl=%0b rl=%0b we=%0b wa=%0d done=%0b cc=%0d required busy=%0b wmem=%0d rd=%0d wl=%0b rl=%0b we=%0b wa=%0d done=%0b cc=%0d",
               name, cyc, got.busy, got.wmem, got.rd, got.wl, got.rl, got.we, got.wa, got.done, got.cc,
               exp.busy, exp.wmem, exp.rd, exp.wl, exp.rl, exp.we, exp.wa, exp.done, exp.cc);
   endtask

   // mode 0: single go pulse; 1: extra go pulses at cycles 5 and 12; 2: go held for back-to-back runs
   task automatic run_table(input string name, input int sel, input int n, input int obase,
                            input int mode, input logic [11:0] prd, input logic [11:0] pwr);
      vec_t tbl[64];
      int   ncyc, lc, j, writes, dones, runs;
      obs_t got;
      ncyc = (mode == 2) ? 2 * (n + 5) : n + 6;
      runs = (mode == 2) ? 2 : 1;
      for (int c = 1; c <= ncyc; c++) begin
         if (mode == 2) begin
            j  = (c - 1) / (n + 5);
            lc = (c - 1) % (n + 5) + 1;
         end else begin
            j  = 0;
            lc = c;
         end
         tbl[c].go       = (mode == 2) ? (c < n + 7) : (mode == 1) ? (c == 5 || c == 12) : 1'b0;
         tbl[c].exp.busy = (lc <= n + 4);
         tbl[c].exp.wmem = 12'd0;
         tbl[c].exp.wl   = (lc == 2);
         if (lc >= 2 && lc <= n + 1)   tbl[c].exp.rd = 12'(lc - 2);
         else if (lc > n + 1 || j > 0) tbl[c].exp.rd = 12'(n - 1);
         else                          tbl[c].exp.rd = prd;
         tbl[c].exp.rl   = (lc >= 3 && lc <= n + 2);
         tbl[c].exp.we   = (lc >= 6 && lc <= n + 3);
         if (lc >= 6 && lc <= n + 3)   tbl[c].exp.wa = 12'(obase + lc - 6);
         else if (lc > n + 3 || j > 0) tbl[c].exp.wa = 12'(obase + n - 3);
         else                          tbl[c].exp.wa = pwr;
         tbl[c].exp.done = (lc == n + 4);
         if (!PERF)           tbl[c].exp.cc = 16'd0;
         else if (lc <= n + 4) tbl[c].exp.cc = 16'(lc - 1);
         else                  tbl[c].exp.cc = 16'(n + 4);
      end

      writes = 0;
      dones  = 0;
      @(negedge clk);
      set_go(sel, 1'b1);
      @(posedge clk);
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         set_go(sel, tbl[c].go);
         got = (sel == 0) ? obs_a : obs_b;
         checks++;
         if (got !== tbl[c].exp) begin
            failures++;
            show_fail(name, c, got, tbl[c].exp);
         end
         if (got.we)   writes++;
         if (got.done) dones++;
      end
      set_go(sel, 1'b0);
      checks++;
      if (writes != runs * (n - 2) || dones != runs) begin
         failures++;
         $display("FAIL %s_counts writes=%0d dones=%0d required writes=%0d dones=%0d",
                  name, writes, dones, runs * (n - 2), runs);
      end
      $display("run %s: %0d cycles, writes=%0d dones=%0d", name, ncyc, writes, dones);
   endtask

   initial begin
      int   bad;
      obs_t zero;
      zero = '0;

      // reset acts before any clock edge
      #3;
      checks++;
      if (obs_a !== zero || obs_b !== zero) begin
         failures++;
         show_fail("reset_async_a", 0, obs_a, zero);
      end
      @(negedge clk);
      reset_b = 1'b1;

      // go low: stays idle
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (busy_a || busy_b || done_a || done_b) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL idle_no_go busy_cycles=%0d required 0", bad);
      end

      run_table("basic", 0, 16, 256, 0, 12'd0, 12'd0);
      run_table("go_ignored", 0, 16, 256, 1, 12'd15, 12'd269);
      run_table("back_to_back", 0, 16, 256, 2, 12'd15, 12'd269);

      // reset in cycle 9 of a run
      @(negedge clk);
      go_a = 1'b1;
      @(posedge clk);
      go_a = 1'b0;
      repeat (9) @(negedge clk);
      #1 reset_b = 1'b0;
      #1;
      checks++;
      if (obs_a !== zero) begin
         failures++;
         show_fail("reset_midrun", 9, obs_a, zero);
      end
      repeat (2) @(negedge clk);
      reset_b = 1'b1;
      bad = 0;
      repeat (25) begin
         @(negedge clk);
         if (done_a || busy_a || we_a) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL reset_abandon active_cycles=%0d required 0", bad);
      end
      run_table("after_reset", 0, 16, 256, 0, 12'd0, 12'd0);

      run_table("small_wrap", 1, 3, 4095, 0, 12'd0, 12'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
- REQ-001 Parameters SHALL be, one per line:
  - ADDR_W, 12, width of all SRAM addresses.
  - N_ROWS, 16, input rows per image; legal range 3..2^ADDR_W-1.
  - IN_BASE, 0, input-SRAM address of row 0.
  - OUT_BASE, 256, output-SRAM address of output row 0.
  - W_ADDR, 0, weight-memory address of the kernel word.
- REQ-002 Ports SHALL be, one per line:
  - clk  in  1  single clock; all state changes on its rising edge.
  - reset_b  in  1  asynchronous, active-low reset.
  - go  in  1  start request, sampled only in IDLE.
  - busy  out  1  high while an image is being processed.
  - dut_wmem_read_address  out  ADDR_W  weight-memory read address.
  - dut_sram_read_address  out  ADDR_W  input-SRAM read address.
  - weight_load  out  1  datapath captures weight read data this cycle.
  - row_load  out  1  datapath shifts in input read data this cycle.
  - dut_sram_write_enable  out  1  output-SRAM write strobe.
  - dut_sram_write_address  out  ADDR_W  output-SRAM write address.
  - done  out  1  one-cycle completion pulse.
  - cycle_count  out  16  processing-time counter; see Configuration.

Function
- REQ-003 The FSM SHALL have states IDLE, FETCH_W, STREAM, DRAIN and DONE, all registered.
- REQ-004 Both memories SHALL have a read latency of exactly one cycle. The block SHALL assert each load strobe in the cycle after it issues the matching address.
- REQ-005 IDLE with go=1 at edge T0:
  - next state is FETCH_W;
  - busy is 1 from T0;
  - row counter r clears to 0.
- REQ-006 IDLE with go=0: the FSM SHALL stay in IDLE.
- REQ-007 FETCH_W SHALL last one cycle, drive dut_wmem_read_address=W_ADDR, and then go to STREAM.
- REQ-008 STREAM behaviour:
  - first cycle: weight_load=1;
  - each cycle: dut_sram_read_address=IN_BASE+r, then r increments;
  - after the cycle issuing r=N_ROWS-1, go to DRAIN.
- REQ-009 row_load SHALL be 1 in the cycle after each row read, giving exactly N_ROWS pulses.
- REQ-010 Writes:
  - in the cycle after row_load for row k with k>=2: dut_sram_write_enable=1 and dut_sram_write_address=OUT_BASE+(k-2);
  - writes for k<2 SHALL be suppressed;
  - total writes SHALL be exactly N_ROWS-2.
- REQ-011 DRAIN SHALL hold until the last write (k=N_ROWS-1) has been issued, then go to DONE.
- REQ-012 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE with busy=0.
- REQ-013 Timing, counted from T0 = cycle 0 (N = N_ROWS):
  - FETCH_W: cycle 1;
  - reads: cycles 2..N+1;
  - row_load: cycles 3..N+2;
  - writes: cycles 6..N+3;
  - done: cycle N+4.
- REQ-014 go asserted while busy=1 SHALL be ignored, with no restart or queuing. go held high through DONE SHALL start a new run in the first IDLE cycle.
- REQ-015 When not valid, address outputs SHALL hold their last value, and strobes SHALL be 0.
- REQ-016 Address arithmetic SHALL be modulo 2^ADDR_W with wrap-around and no error flag.

Reset
- REQ-017 reset_b=0 SHALL immediately force IDLE and clear r and every output, including dut_sram_write_enable, busy and cycle_count, to 0, independent of clk.
- REQ-018 Reset mid-operation SHALL abandon the run with no done pulse. After reset_b rises, the block SHALL wait for a fresh go.

Configuration
- REQ-019 The macro CONV_SEQ_PERF_COUNT_EN SHALL select the cycle_count behaviour:
  - Defined:
    - cycle_count clears on the accepting go;
    - increments each cycle busy=1, saturating at 16'hFFFF;
    - holds its value in IDLE until the next go.
    - A run with N_ROWS=16 SHALL end with cycle_count=20 (cycles 1..20).
  - Undefined: cycle_count is tied to 0 and no counter logic is built.

Verification
- REQ-020 go pulse with N_ROWS=16 -> read addresses 0..15 in cycles 2..17, 14 writes to addresses 256..269 in cycles 6..19, done in cycle 20, busy=0 in cycle 21.
- REQ-021 go pulsed at cycles 5 and 12 of a run -> exactly one run; write count stays 14.
- REQ-022 go held high continuously -> back-to-back runs with one IDLE cycle between done and the next FETCH_W.
- REQ-023 reset_b=0 at cycle 9 -> all outputs 0 before the next clk edge, and no done pulse; a later go gives a full correct run.
- REQ-024 N_ROWS=3, OUT_BASE=4095 -> one write at address 4095, and done in cycle 7.
- REQ-025 CONV_SEQ_PERF_COUNT_EN defined -> cycle_count=20 after the run and held in IDLE; undefined -> cycle_count=0 throughout.
